shift_sequencer: RTL and testbench

- Multi-cycle shifter-operand unit for the embedded ARM-subset CPU.
- Takes a 32-bit value, shift type and amount, and applies the shift in steps of at most STEP bits per clock.
- Produces the full ARM result and shifter carry-out, with a start/done handshake.
- Replaces the single-cycle barrel shifter in the area-reduced core. The control unit sequences it between operand fetch and ALU execute.

---
 rtl/shift_sequencer_if.sv | 22 ++
 rtl/shift_sequencer.sv | 96 +++++++++
 tb/tb_shift_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: start/done handshake, operand and result bundle for shift_sequencer.
interface shift_sequencer_if;
    logic        start;
    logic        abort;
    logic [31:0] shift_val;
    logic [7:0]  shift_amt;
    logic [1:0]  shift_type;
    logic        imm_form;
    logic        carry_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry_out;
    modport master (
        output start, abort, shift_val, shift_amt, shift_type, imm_form, carry_in,
        input  busy, done, result, carry_out
    );
    modport slave (
        input  start, abort, shift_val, shift_amt, shift_type, imm_form, carry_in,
        output busy, done, result, carry_out
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle ARM shifter operand unit, at most STEP bits per clock.
// Define SHIFT_SEQ_RRX_EN to make ROR #0 (immediate form) perform RRX.
module shift_sequencer #(
    parameter int STEP = 4
) (
    input logic             clk,
    input logic             rst,
    shift_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t      state, state_n;
    logic [31:0] v, work, res, sp_res, step_res;
    logic [7:0]  amt;
    logic [5:0]  rem, k;
    logic [1:0]  typ;
    logic        car, sp_c, step_c, special, accept;
    assign v   = bus.shift_val;
    assign amt = bus.shift_amt;
    // Out-of-range and #0 encodings resolve at accept without entering SHIFT.
    always_comb begin
        special = 1'b1;
        sp_res  = v;
        sp_c    = bus.carry_in;
        if (amt != 8'd0 || (bus.imm_form && bus.shift_type != 2'b00)) begin
            case (bus.shift_type)
                2'b00: begin
                    special = amt >= 8'd32;
                    sp_res  = '0;
                    sp_c    = amt == 8'd32 && v[0];
                end
                2'b01: begin
                    special = amt == 8'd0 || amt >= 8'd32;
                    sp_res  = '0;
                    sp_c    = amt <= 8'd32 && v[31];
                end
                2'b10: begin
                    special = amt == 8'd0 || amt >= 8'd32;
                    sp_res  = {32{v[31]}};
                    sp_c    = v[31];
                end
                default: if (amt == 8'd0) begin
`ifdef SHIFT_SEQ_RRX_EN
                    sp_res = {bus.carry_in, v[31:1]};
                    sp_c   = v[0];
`endif
                end else begin
                    special = amt[4:0] == 5'd0;
                    sp_c    = v[31];
                end
            endcase
        end
    end
    assign k        = rem < 6'(STEP) ? rem : 6'(STEP);
    assign step_res = typ == 2'b00 ? work << k :
                      typ == 2'b01 ? work >> k :
                      typ == 2'b10 ? 32'($signed(work) >>> k) :
                                     (work >> k) | (work << (6'd32 - k));
    assign step_c   = typ == 2'b00 ? work[5'(6'd32 - k)] : work[5'(k - 6'd1)];
    assign accept   = bus.start && !bus.abort && state != SHIFT;
    always_comb begin
        state_n = state == SHIFT ? (bus.abort ? IDLE : rem == k ? DONE : SHIFT) :
                  accept ? (special ? DONE : SHIFT) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            rem   <= '0;
            typ   <= '0;
            res   <= '0;
            car   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                typ  <= bus.shift_type;
                work <= v;
                rem  <= special ? 6'd0 : {1'b0, amt[4:0]};
                if (special) begin
                    res <= sp_res;
                    car <= sp_c;
                end
            end else if (state == SHIFT && !bus.abort) begin
                work <= step_res;
                rem  <= rem - k;
                if (rem == k) begin
                    res <= step_res;
                    car <= step_c;
                end
            end
        end
    end
    assign bus.busy      = state == SHIFT;
    assign bus.done      = state == DONE;
    assign bus.result    = res;
    assign bus.carry_out = car;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed checks of shift_sequencer with STEP=4 and STEP=1 instances.
module tb_shift_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start4 = 1'b0, start1 = 1'b0, abort4 = 1'b0, abort1 = 1'b0;
    logic [31:0] val = '0;
    logic [7:0]  amt = '0;
    logic [1:0]  typ = '0;
    logic        imm = 1'b0, cin = 1'b0;
    int          compared = 0, mismatched = 0;
    int          edges, busy_cnt;
    shift_sequencer_if i4 ();
    shift_sequencer_if i1 ();
    assign i4.start = start4;
    assign i4.abort = abort4;
    assign i4.shift_val = val;
    assign i4.shift_amt = amt;
    assign i4.shift_type = typ;
    assign i4.imm_form = imm;
    assign i4.carry_in = cin;
    assign i1.start = start1;
    assign i1.abort = abort1;
    assign i1.shift_val = val;
    assign i1.shift_amt = amt;
    assign i1.shift_type = typ;
    assign i1.imm_form = imm;
    assign i1.carry_in = cin;
    shift_sequencer #(.STEP(4)) u4 (.clk(clk), .rst(rst), .bus(i4));
    shift_sequencer #(.STEP(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    // Called at a negedge; holds start over exactly one rising edge.
    task automatic launch(input bit sel, input logic [31:0] v, input logic [7:0] a,
                          input logic [1:0] t, input logic im, input logic c);
        val = v; amt = a; typ = t; imm = im; cin = c;
        if (sel) start1 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
    endtask
    task automatic wait_done(input bit sel, output int e, output int b);
        e = 1;
        b = 0;
        while (!(sel ? i1.done : i4.done) && e < 100) begin
            if (sel ? i1.busy : i4.busy) b++;
            @(negedge clk);
            e++;
        end
    endtask
    task automatic op4(input string tag, input logic [31:0] v, input logic [7:0] a,
                       input logic [1:0] t, input logic im, input logic c,
                       input logic [31:0] er, input logic ec, input int ee);
        launch(1'b0, v, a, t, im, c);
        wait_done(1'b0, edges, busy_cnt);
        chk({tag, "_edges"}, edges, ee);
        chk({tag, "_res"}, i4.result, er);
        chk({tag, "_c"}, 32'(i4.carry_out), 32'(ec));
        @(negedge clk);
    endtask
    initial begin
        #3;
        chk("rst_res", i4.result, 32'h0);
        chk("rst_c", 32'(i4.carry_out), 32'h0);
        chk("rst_busy", 32'(i4.busy), 32'h0);
        chk("rst_done", 32'(i4.done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        launch(1'b0, 32'h0800_0001, 8'd5, 2'b00, 1'b0, 1'b0);
        wait_done(1'b0, edges, busy_cnt);
        chk("lsl5_edges", edges, 3);
        chk("lsl5_busy", busy_cnt, 2);
        chk("lsl5_res", i4.result, 32'h0000_0020);
        chk("lsl5_c", 32'(i4.carry_out), 32'h1);
        @(negedge clk);
        chk("done_pulse", 32'(i4.done), 32'h0);
        op4("asr40", 32'h8000_0000, 8'd40, 2'b10, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1);
        op4("lsr40", 32'h8000_0000, 8'd40, 2'b01, 1'b0, 1'b0, 32'h0, 1'b0, 1);
        op4("ror4", 32'h0000_00F1, 8'd4, 2'b11, 1'b0, 1'b0, 32'h1000_000F, 1'b0, 2);
        op4("ror36", 32'h0000_00F1, 8'd36, 2'b11, 1'b0, 1'b0, 32'h1000_000F, 1'b0, 2);
        op4("ror32", 32'h0000_00F1, 8'd32, 2'b11, 1'b0, 1'b0, 32'h0000_00F1, 1'b0, 1);
        op4("lsr_i0", 32'h8000_0000, 8'd0, 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 1);
        op4("lsr_r0", 32'h8000_0000, 8'd0, 2'b01, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1);
        op4("lsl32", 32'h0000_0001, 8'd32, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        op4("asr4", 32'h8000_0010, 8'd4, 2'b10, 1'b0, 1'b0, 32'hF800_0001, 1'b0, 2);
        op4("lsr9", 32'h0000_0300, 8'd9, 2'b01, 1'b0, 1'b0, 32'h0000_0001, 1'b1, 4);
`ifdef SHIFT_SEQ_RRX_EN
        op4("rrx", 32'h0000_0003, 8'd0, 2'b11, 1'b1, 1'b1, 32'h8000_0001, 1'b1, 1);
`else
        op4("ror_i0", 32'h0000_0003, 8'd0, 2'b11, 1'b1, 1'b1, 32'h0000_0003, 1'b1, 1);
`endif
        launch(1'b0, 32'h0000_0001, 8'd8, 2'b00, 1'b0, 1'b0);
        wait_done(1'b0, edges, busy_cnt);
        chk("b2b_first", i4.result, 32'h0000_0100);
        launch(1'b0, 32'h0000_0001, 8'd4, 2'b00, 1'b0, 1'b0);
        chk("b2b_done_low", 32'(i4.done), 32'h0);
        chk("b2b_busy", 32'(i4.busy), 32'h1);
        wait_done(1'b0, edges, busy_cnt);
        chk("b2b_edges", edges, 2);
        chk("b2b_res", i4.result, 32'h0000_0010);
        chk("b2b_c", 32'(i4.carry_out), 32'h0);
        @(negedge clk);
        launch(1'b1, 32'h0000_0003, 8'd31, 2'b00, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        launch(1'b1, 32'hFFFF_FFFF, 8'd1, 2'b10, 1'b0, 1'b1);
        wait_done(1'b1, edges, busy_cnt);
        chk("ign_edges", edges, 27);
        chk("ign_res", i1.result, 32'h8000_0000);
        chk("ign_c", 32'(i1.carry_out), 32'h1);
        @(negedge clk);
        launch(1'b1, 32'hFFFF_FFFF, 8'd31, 2'b00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        abort1 = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        start1 = 1'b0;
        chk("abort_busy", 32'(i1.busy), 32'h0);
        chk("abort_done", 32'(i1.done), 32'h0);
        chk("abort_res", i1.result, 32'h8000_0000);
        chk("abort_c", 32'(i1.carry_out), 32'h1);
        val = 32'h0000_0005; amt = 8'd0; typ = 2'b00; imm = 1'b0;
        abort1 = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        start1 = 1'b0;
        chk("idle_abort_done", 32'(i1.done), 32'h0);
        chk("idle_abort_res", i1.result, 32'h8000_0000);
        launch(1'b1, 32'h0000_0001, 8'd31, 2'b00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mrst_busy", 32'(i1.busy), 32'h0);
        chk("mrst_done", 32'(i1.done), 32'h0);
        chk("mrst_res", i1.result, 32'h0);
        chk("mrst_c", 32'(i1.carry_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
